// File: rtl/stage_decision_accumulator.sv
// Face-detection cascade stage accumulator: sums signed weak-classifier votes per stage
// with saturation, compares against the stage threshold and advances or issues a verdict.
module stage_decision_accumulator #(
    parameter int DATA_WIDTH_16 = 16,
    parameter int ACC_WIDTH     = 20,
    parameter int NUM_STAGES    = 25,
    parameter int STAGE_WIDTH   = 5
) (
    input  logic                     clk_fpga,
    input  logic                     reset_fpga,
    input  logic                     i_start,
    input  logic                     i_vote_valid,
    input  logic [DATA_WIDTH_16-1:0] i_vote,
    input  logic                     i_vote_last,
    input  logic [DATA_WIDTH_16-1:0] i_stage_threshold,
    output logic                     o_vote_ready,
    output logic [STAGE_WIDTH-1:0]   o_stage_index,
    output logic [ACC_WIDTH-1:0]     o_stage_sum,
    output logic                     o_next_stage,
    output logic                     o_done,
    output logic                     o_is_candidate,
    output logic [STAGE_WIDTH-1:0]   o_reject_stage
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DECIDE,
        S_DONE
    } state_t;

    localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(NUM_STAGES - 1);
    localparam logic signed [ACC_WIDTH-1:0] SUM_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SUM_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                       state_q;
    logic signed [ACC_WIDTH-1:0]  sum_q;
    logic signed [ACC_WIDTH-1:0]  thr_q;
    logic [STAGE_WIDTH-1:0]       stage_q;
    logic [STAGE_WIDTH-1:0]       reject_q;
    logic                         ready_q;
    logic                         next_q;
    logic                         done_q;
    logic                         cand_q;

    logic signed [ACC_WIDTH:0]    vote_ext;
    logic signed [ACC_WIDTH:0]    sum_wide;
    logic signed [ACC_WIDTH-1:0]  sum_d;
    logic signed [ACC_WIDTH-1:0]  thr_d;

    // One guard bit above the accumulator exposes overflow for saturation.
    assign vote_ext = {{(ACC_WIDTH+1-DATA_WIDTH_16){i_vote[DATA_WIDTH_16-1]}}, i_vote};
    assign sum_wide = {sum_q[ACC_WIDTH-1], sum_q} + vote_ext;
    assign thr_d    = {{(ACC_WIDTH-DATA_WIDTH_16){i_stage_threshold[DATA_WIDTH_16-1]}},
                       i_stage_threshold};

    always_comb begin
        sum_d = sum_wide[ACC_WIDTH-1:0];
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            sum_d = sum_wide[ACC_WIDTH] ? SUM_MIN : SUM_MAX;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_fpga or posedge reset_fpga) begin
        if (reset_fpga) begin
            state_q  <= S_IDLE;
            sum_q    <= '0;
            thr_q    <= '0;
            stage_q  <= '0;
            reject_q <= '0;
            ready_q  <= 1'b0;
            next_q   <= 1'b0;
            done_q   <= 1'b0;
            cand_q   <= 1'b0;
        end else begin
            next_q <= 1'b0;
            done_q <= 1'b0;
            if (i_start) begin
                // A start from any state restarts the window; a coincident vote is dropped.
                state_q  <= S_ACCUM;
                sum_q    <= '0;
                stage_q  <= '0;
                reject_q <= '0;
                cand_q   <= 1'b0;
                ready_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_ACCUM: begin
                        if (i_vote_valid && ready_q) begin
                            sum_q <= sum_d;
                            if (i_vote_last) begin
                                thr_q   <= thr_d;
                                ready_q <= 1'b0;
                                state_q <= S_DECIDE;
                            end
                        end
                    end
                    S_DECIDE: begin
                        if (sum_q >= thr_q && stage_q != LAST_STAGE) begin
                            stage_q <= stage_q + STAGE_WIDTH'(1);
                            sum_q   <= '0;
                            next_q  <= 1'b1;
                            ready_q <= 1'b1;
                            state_q <= S_ACCUM;
                        end else begin
                            cand_q   <= (sum_q >= thr_q);
                            reject_q <= stage_q;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                    default: begin
                        ready_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_vote_ready   = ready_q;
    assign o_stage_index  = stage_q;
    assign o_stage_sum    = sum_q;
    assign o_next_stage   = next_q;
    assign o_done         = done_q;
    assign o_is_candidate = cand_q;
    assign o_reject_stage = reject_q;

endmodule

// File: tb/tb_stage_decision_accumulator.sv
// Directed bench for stage_decision_accumulator with 3 stages and a 17-bit accumulator
// so that cascade completion and saturation are both reachable in a few cycles.
module tb_stage_decision_accumulator;

    localparam int DW = 16;
    localparam int AW = 17;
    localparam int NS = 3;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          vvalid = 1'b0;
    logic [DW-1:0] vote = '0;
    logic          vlast = 1'b0;
    logic [DW-1:0] thr = '0;
    logic          ready;
    logic [SW-1:0] stage;
    logic [AW-1:0] sum;
    logic          nxt;
    logic          done;
    logic          cand;
    logic [SW-1:0] rej;

    int checks = 0;
    int failures = 0;

    stage_decision_accumulator #(
        .DATA_WIDTH_16(DW), .ACC_WIDTH(AW), .NUM_STAGES(NS), .STAGE_WIDTH(SW)
    ) dut (
        .clk_fpga(clk), .reset_fpga(rst), .i_start(start), .i_vote_valid(vvalid),
        .i_vote(vote), .i_vote_last(vlast), .i_stage_threshold(thr),
        .o_vote_ready(ready), .o_stage_index(stage), .o_stage_sum(sum),
        .o_next_stage(nxt), .o_done(done), .o_is_candidate(cand), .o_reject_stage(rej)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic st;
        logic vv;
        int   vt;
        logic lst;
        int   th;
        logic e_ready;
        int   e_stage;
        int   e_sum;
        logic e_next;
        logic e_done;
        logic e_cand;
        int   e_rej;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic vv, input int vt, input logic lst, input int th,
                       input logic r, input int s, input int sm, input logic n, input logic d,
                       input logic c, input int rj);
        vecs.push_back('{st, vv, vt, lst, th, r, s, sm, n, d, c, rj});
    endtask

    task automatic drive(input logic st, input logic vv, input int vt, input logic lst, input int th);
        start  = st;
        vvalid = vv;
        vote   = DW'(vt);
        vlast  = lst;
        thr    = DW'(th);
    endtask

    function automatic int sum_int();
        return int'($signed(sum));
    endfunction

    task automatic check_all(input string tag, input logic r, input int s, input int sm,
                             input logic n, input logic d, input logic c, input int rj);
        check({tag, " ready"}, 32'(ready), 32'(r));
        check({tag, " stage"}, 32'(stage), s);
        check({tag, " sum"}, sum_int(), sm);
        check({tag, " next"}, 32'(nxt), 32'(n));
        check({tag, " done"}, 32'(done), 32'(d));
        check({tag, " cand"}, 32'(cand), 32'(c));
        check({tag, " rej"}, 32'(rej), rj);
    endtask

    initial begin
        int exp_sum;

        // All three stages pass with votes 100,-20,30 against threshold 110.
        add(1,0,0,0,0,     1,0,0,0,0,0,0);
        for (int s = 0; s < NS; s++) begin
            add(0,1,100,0,0,   1,s,100,0,0,0,0);
            add(0,1,-20,0,0,   1,s,80,0,0,0,0);
            add(0,1,30,1,110,  0,s,110,0,0,0,0);
            if (s < NS-1) add(0,0,0,0,0, 1,s+1,0,1,0,0,0);
            else          add(0,0,0,0,0, 0,s,110,0,1,1,2);
        end
        add(0,0,0,0,0,     0,2,110,0,0,1,2);
        add(0,1,5,0,0,     0,2,110,0,0,1,2);   // vote in DONE ignored
        // Stage 0 fails: 50+40=90 < 91; start coincident with a vote drops it.
        add(1,1,77,0,0,    1,0,0,0,0,0,0);
        add(0,1,50,0,0,    1,0,50,0,0,0,0);
        add(0,1,40,1,91,   0,0,90,0,0,0,0);
        add(0,0,0,0,0,     0,0,90,0,1,0,0);
        add(0,0,0,0,0,     0,0,90,0,0,0,0);
        // Abort during DECIDE of stage 1 (single-vote stages).
        add(1,0,0,0,0,     1,0,0,0,0,0,0);
        add(0,1,10,1,5,    0,0,10,0,0,0,0);
        add(0,0,0,0,0,     1,1,0,1,0,0,0);
        add(0,1,3,1,0,     0,1,3,0,0,0,0);
        add(1,0,0,0,0,     1,0,0,0,0,0,0);
        add(0,0,0,0,0,     1,0,0,0,0,0,0);
        // Negative threshold, equal-sum boundary: -7 >= -7 passes.
        add(0,1,-7,1,-7,   0,0,-7,0,0,0,0);
        add(0,0,0,0,0,     1,1,0,1,0,0,0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        drive(0,1,123,0,0);
        @(posedge clk);
        #1;
        check_all("idle_vote", 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].vv, vecs[i].vt, vecs[i].lst, vecs[i].th);
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", i), vecs[i].e_ready, vecs[i].e_stage, vecs[i].e_sum,
                      vecs[i].e_next, vecs[i].e_done, vecs[i].e_cand, vecs[i].e_rej);
        end

        // Positive saturation at 2^16-1.
        drive(1,0,0,0,0);
        @(posedge clk);
        #1;
        exp_sum = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0,1,32767,0,0);
            @(posedge clk);
            #1;
            exp_sum = (exp_sum + 32767 > 65535) ? 65535 : exp_sum + 32767;
            check($sformatf("sat_pos%0d", i), sum_int(), exp_sum);
        end
        // Negative saturation at -2^16.
        drive(1,0,0,0,0);
        @(posedge clk);
        #1;
        exp_sum = 0;
        for (int i = 0; i < 8; i++) begin
            drive(0,1,-32768,0,0);
            @(posedge clk);
            #1;
            exp_sum = (exp_sum - 32768 < -65536) ? -65536 : exp_sum - 32768;
            check($sformatf("sat_neg%0d", i), sum_int(), exp_sum);
        end

        // Asynchronous reset mid-ACCUM clears outputs without a clock edge.
        drive(1,0,0,0,0);
        @(posedge clk);
        #1;
        drive(0,1,100,0,0);
        @(posedge clk);
        #1;
        check("pre_reset sum", sum_int(), 100);
        #2 rst = 1'b1;
        #1;
        check_all("async_reset", 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("post_reset", 0, 0, 0, 0, 0, 0, 0);
        drive(0,0,0,0,0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stage_decision_accumulator.md
# stage_decision_accumulator

Sits directly downstream of the per-stage weak-classifier evaluator in the face-detection cascade. Each weak classifier yields a signed vote (its selected left/right word). This block sums the votes of the current stage and compares the sum against that stage's threshold. It then either advances the cascade to the next stage or terminates the window with a face/non-face verdict.

## Interface
Parameters:
- DATA_WIDTH_16, 16, width of signed vote and stage threshold
- ACC_WIDTH, 20, width of signed stage accumulator (must be > DATA_WIDTH_16)
- NUM_STAGES, 25, number of cascade stages
- STAGE_WIDTH, 5, width of stage index (2^STAGE_WIDTH >= NUM_STAGES)

Ports:
- clk_fpga  in  1  system clock; all logic on rising edge
- reset_fpga  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse: begin evaluating a new window at stage 0
- i_vote_valid  in  1  vote present on i_vote
- i_vote  in  DATA_WIDTH_16  signed weak-classifier vote
- i_vote_last  in  1  qualifies i_vote_valid: final vote of current stage
- i_stage_threshold  in  DATA_WIDTH_16  signed threshold of current stage, sampled with the last vote
- o_vote_ready  out  1  block accepts a vote this cycle
- o_stage_index  out  STAGE_WIDTH  stage currently being evaluated
- o_stage_sum  out  ACC_WIDTH  signed running sum of current stage
- o_next_stage  out  1  one-cycle pulse: stage passed, upstream starts next stage
- o_done  out  1  one-cycle pulse: verdict valid
- o_is_candidate  out  1  verdict: 1 = all stages passed; held until next i_start
- o_reject_stage  out  STAGE_WIDTH  stage that failed (NUM_STAGES-1 when candidate); held with verdict

## Operation
- States: IDLE, ACCUM, DECIDE, DONE.
- IDLE: o_vote_ready=0. On i_start, go to ACCUM and set stage=0, sum=0, o_is_candidate=0.
- ACCUM: o_vote_ready=1. A vote is accepted when i_vote_valid and o_vote_ready are both 1. Sign-extend the vote and add it to sum with saturation at ±(2^(ACC_WIDTH-1)) limits (max positive / min negative). If i_vote_last is set, latch i_stage_threshold (sign-extended) and go to DECIDE.
- DECIDE: o_vote_ready=0. Stage passes when sum >= threshold (signed compare).
  - Pass with stage < NUM_STAGES-1: stage+1, sum=0, pulse o_next_stage, return to ACCUM.
  - Pass with stage = NUM_STAGES-1: o_is_candidate=1, o_reject_stage=stage, pulse o_done, go to DONE.
  - Fail: o_is_candidate=0, o_reject_stage=stage, pulse o_done, go to DONE.
- DONE: o_vote_ready=0. Verdict is held. i_start re-enters ACCUM as from IDLE.
- i_start in ACCUM or DECIDE aborts the current window. Restart at stage 0 with sum=0, and do not pulse o_done or o_next_stage.
- i_start takes priority over a simultaneous vote; that vote is dropped.
- Votes with i_vote_valid while o_vote_ready=0 are ignored.
- Reset values: state IDLE, all outputs 0, sum 0, stage 0, latched threshold 0. Reset mid-evaluation discards all progress.

## Timing
- Vote accepted in cycle N is reflected in o_stage_sum at cycle N+1.
- Last vote at cycle N: DECIDE during N+1. o_next_stage or o_done is high during N+2, together with the updated o_stage_index, o_is_candidate and o_reject_stage.
- On pass, o_vote_ready returns high in N+2. A next-stage vote may be accepted in N+2 at the earliest.
- A single-vote stage is legal (vote with i_vote_last as first vote).
- o_next_stage and o_done are never high in the same cycle. Each is exactly one cycle wide.
- i_start at cycle N: o_vote_ready=1 and o_stage_index=0 at N+1.

## Test plan
- Reset asserted asynchronously mid-ACCUM -> all outputs 0 immediately; after release, state IDLE and o_vote_ready=0.
- NUM_STAGES=3: start, per stage votes 100,-20,30 (last) with threshold 110 (sum 110) -> o_next_stage twice; then o_done with o_is_candidate=1, o_reject_stage=2; exact cycle spacing per Timing.
- Stage 0 votes 50,40 (last), threshold 91 -> o_done at last+2, o_is_candidate=0, o_reject_stage=0, no o_next_stage.
- Saturation: ACC_WIDTH=17, eight votes of +32767 -> o_stage_sum=65535 (not wrapped); eight votes of -32768 -> -65536.
- i_start during DECIDE of stage 1 -> no o_done/o_next_stage; next cycle stage=0, sum=0, o_vote_ready=1.
- i_start coincident with i_vote_valid=1 -> vote dropped, o_stage_sum=0 next cycle; votes asserted in IDLE/DONE leave sum unchanged.
